pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised, registered next-PC generator for the npc core, successor to the single-cycle combinational pc-select.
- Holds the architectural fetch PC and offers it to the IFU with a valid/ready handshake.
- Resolves branch/jump outcomes from EXU and CSR trap/return redirects internally, with fixed priority.
- Flags misaligned targets, supports an ebreak halt, and counts taken redirects.

Parameters:
- XLEN, 32: PC and operand width.
- RESET_PC, 32'h8000_0000: PC value after reset.
- INST_BYTES, 4: sequential increment.
- CNT_W, 32: width of the taken-redirect counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EXU presents a resolved instruction this cycle
- ex_branch  in  3  000 none, 001 jal, 010 jalr, 011 reserved, 100 beq, 101 bne, 110 blt, 111 bge
- ex_zero  in  1  ALU result zero
- ex_less  in  1  ALU less-than (signedness chosen by EXU)
- ex_pc  in  XLEN  PC of the EXU instruction
- ex_imm  in  XLEN  sign-extended immediate
- ex_rs1  in  XLEN  rs1 value, used by jalr
- csr_redirect  in  1  trap entry or mret
- csr_target  in  XLEN  mtvec/mepc value
- halt  in  1  ebreak retired
- if_ready  in  1  IFU accepts if_pc
- if_valid  out  1  if_pc valid
- if_pc  out  XLEN  current fetch PC
- flush  out  1  one-cycle pulse: younger in-flight work is stale
- misalign  out  1  one-cycle pulse: taken target not INST_BYTES aligned
- taken_cnt  out  CNT_W  number of redirects performed

Behaviour:
- Reset, sampled at the clk edge only:
  - if_pc=RESET_PC, if_valid=0, flush=0, misalign=0, taken_cnt=0, state=BOOT.
  - rst overrides every other input in the same cycle.
- State machine:
  - BOOT -> RUN unconditionally after one cycle. if_valid=0 in BOOT.
  - RUN: if_valid=1.
  - RUN -> HALT when halt=1. In HALT, if_valid=0, all redirect inputs are ignored, and only rst exits.
- Taken decision, combinational. Applies only when ex_valid=1:
  - jal and jalr: always taken.
  - beq: taken when ex_zero=1. bne: taken when ex_zero=0.
  - blt: taken when ex_less=1. bge: taken when ex_less=0.
  - 000 and 011: not taken.
- Branch target:
  - jalr: (ex_rs1+ex_imm) with bit0 cleared.
  - All others: ex_pc+ex_imm.
  - Arithmetic is modulo 2^XLEN, and wrap-around is legal.
- Next-PC priority in RUN, evaluated each cycle, with the update visible the following cycle:
  1. csr_redirect: if_pc<=csr_target, flush<=1, taken_cnt+1.
  2. Taken branch with an aligned target (target mod INST_BYTES==0): if_pc<=target, flush<=1, taken_cnt+1.
  3. Taken branch with a misaligned target: if_pc unchanged by this event, misalign<=1, no flush, no count. The sequential rule below still applies. The trap unit answers with csr_redirect later.
  4. if_valid && if_ready: if_pc<=if_pc+INST_BYTES (wraps).
  5. Otherwise hold if_pc. An offered PC stays stable until accepted.
- A redirect overrides the handshake: if if_ready=0, the pending offer is abandoned and replaced. if_valid stays 1.
- csr_redirect together with a taken branch: csr wins. The branch is dropped, counted once.
- halt together with a redirect: HALT is entered, and the redirect is applied to if_pc but never offered (if_valid=0).
- csr_target is used as given. Its alignment is the CSR unit's responsibility.
- flush and misalign are registered, high exactly one cycle per event. Back-to-back events give consecutive pulses.
- taken_cnt wraps at 2^CNT_W.
- Latency: input event at edge N -> new if_pc/flush visible after edge N, i.e. during cycle N+1.

Decomposition:
- Shared package pc_pkg holds:
  - Branch-type localparams: BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE.
  - State encoding: BOOT/RUN/HALT.
  - Default RESET_PC.
- One combinational sub-module, br_resolve: ex_valid/ex_branch/ex_zero/ex_less/operands -> taken, target, misaligned.
- pc_gen keeps the state register, PC register, pulses and counter.

Test Plan:
- Reset release, if_ready=1 -> cycle 1 if_valid=0, if_pc=0x80000000; then if_pc 0x80000000, 0x80000004, 0x80000008.
- if_ready=0 for 3 cycles at if_pc=0x80000010 -> if_pc held at 0x80000010, if_valid=1; if_ready=1 -> 0x80000014 next cycle.
- Branch resolution:
  - beq ex_zero=1, ex_pc=0x80000020, ex_imm=0xFFFFFFF0 -> if_pc=0x80000010, flush pulse, taken_cnt=1.
  - bne ex_zero=1 -> sequential, no flush.
  - jalr ex_rs1=0x80000101, ex_imm=0 -> if_pc=0x80000100.
  - jal ex_imm=0x2 -> misalign pulse, PC sequential.
- Same cycle csr_redirect=1 (csr_target=0x80001000) and jal to 0x80000200 -> if_pc=0x80001000, single flush, taken_cnt +1; if_ready=0 during the event is ignored.
- halt=1 -> if_valid=0 from the next cycle; later csr_redirect ignored; rst=1 mid-halt -> BOOT, if_pc=0x80000000, taken_cnt=0.
- CNT_W=2, four redirects -> taken_cnt wraps to 0; ex_pc=0xFFFFFFFC, ex_imm=8 taken -> if_pc=0x00000004.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC generator.
// Branch encodings, FSM states and the default boot address.
package pc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/pc_gen_br_resolve.sv
// Combinational branch/jump resolution for the EXU result.
// Produces the taken flag, the target and its alignment status.
module br_resolve
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4
) (
  input  logic            ex_valid,
  input  logic [2:0]      ex_branch,
  input  logic            ex_zero,
  input  logic            ex_less,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic cond;
  logic [XLEN-1:0] jalr_sum;

  always_comb begin
    cond = 1'b0;
    unique case (ex_branch)
      BR_JAL:  cond = 1'b1;
      BR_JALR: cond = 1'b1;
      BR_BEQ:  cond = ex_zero;
      BR_BNE:  cond = ~ex_zero;
      BR_BLT:  cond = ex_less;
      BR_BGE:  cond = ~ex_less;
      default: cond = 1'b0;
    endcase
  end

  assign taken = ex_valid & cond;

  assign jalr_sum = ex_rs1 + ex_imm;

  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_branch == BR_JALR)
      target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign misaligned =
    (target % XLEN'(INST_BYTES)) != '0;

endmodule

// File: rtl/pc_gen.sv
// Registered next-PC generator with IFU handshake,
// prioritised redirects, ebreak halt and redirect counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int              INST_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [2:0]       ex_branch,
  input  logic             ex_zero,
  input  logic             ex_less,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             csr_redirect,
  input  logic [XLEN-1:0]  csr_target,
  input  logic             halt,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t state, state_n;

  logic            taken;
  logic            misaligned;
  logic [XLEN-1:0] target;

  br_resolve #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_br (
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_zero    (ex_zero),
    .ex_less    (ex_less),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .taken      (taken),
    .target     (target),
    .misaligned (misaligned)
  );

  logic run;
  logic do_csr;
  logic do_br;
  logic do_mis;

  assign run      = (state == ST_RUN);
  assign if_valid = run;

  assign do_csr = run & csr_redirect;
  assign do_br  = run & ~csr_redirect
                & taken & ~misaligned;
  assign do_mis = run & ~csr_redirect
                & taken & misaligned;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_BOOT: state_n = ST_RUN;
      ST_RUN:  if (halt) state_n = ST_HALT;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_BOOT;
    endcase
  end

  logic [XLEN-1:0] pc_n;

  // A redirect replaces any pending offer, even if not accepted.
  always_comb begin
    pc_n = if_pc;
    if (do_csr)
      pc_n = csr_target;
    else if (do_br)
      pc_n = target;
    else if (run && if_ready)
      pc_n = if_pc + XLEN'(INST_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BOOT;
      if_pc     <= RESET_PC;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      state     <= state_n;
      if_pc     <= pc_n;
      flush     <= do_csr | do_br;
      misalign  <= do_mis;
      if (do_csr || do_br)
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against
// a cycle-level reference model of the fetch PC.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_branch;
  logic        ex_zero;
  logic        ex_less;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        csr_redirect;
  logic [31:0] csr_target;
  logic        halt;
  logic        if_ready;

  logic        if_valid, if_valid2;
  logic [31:0] if_pc, if_pc2;
  logic        flush, flush2;
  logic        misalign, misalign2;
  logic [31:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_less(ex_less),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .csr_redirect(csr_redirect), .csr_target(csr_target),
    .halt(halt), .if_ready(if_ready),
    .if_valid(if_valid), .if_pc(if_pc),
    .flush(flush), .misalign(misalign),
    .taken_cnt(taken_cnt)
  );

  pc_gen #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_less(ex_less),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .csr_redirect(csr_redirect), .csr_target(csr_target),
    .halt(halt), .if_ready(if_ready),
    .if_valid(if_valid2), .if_pc(if_pc2),
    .flush(flush2), .misalign(misalign2),
    .taken_cnt(taken_cnt2)
  );

  // Reference model: mode 0 boot, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_flush, m_mis;
  logic [31:0] m_cnt;

  function automatic bit ref_taken(
    input logic [2:0] br, input logic z, input logic l);
    case (br)
      3'd1, 3'd2: return 1'b1;
      3'd4: return z;
      3'd5: return !z;
      3'd6: return l;
      3'd7: return !l;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit          tk;
    logic [31:0] tgt;
    if (rst) begin
      m_mode = 0; m_pc = 32'h8000_0000;
      m_flush = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    m_flush = 0; m_mis = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      tk  = ex_valid && ref_taken(ex_branch, ex_zero, ex_less);
      tgt = (ex_branch == 3'd2)
          ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
      if (csr_redirect) begin
        m_pc = csr_target; m_flush = 1; m_cnt++;
      end else if (tk && (tgt % 4 == 0)) begin
        m_pc = tgt; m_flush = 1; m_cnt++;
      end else begin
        m_mis = tk;
        if (if_ready) m_pc = m_pc + 4;
      end
      if (halt) m_mode = 2;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("if_valid",  32'(if_valid),   32'(m_mode == 1));
    chk("if_pc",     if_pc,           m_pc);
    chk("flush",     32'(flush),      32'(m_flush));
    chk("misalign",  32'(misalign),   32'(m_mis));
    chk("taken_cnt", taken_cnt,       m_cnt);
    chk("cnt2",      32'(taken_cnt2), 32'(m_cnt[1:0]));
    chk("pc2",       if_pc2,          m_pc);
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_branch = 3'd0; ex_zero = 0; ex_less = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
  endtask

  initial begin
    rst = 1; idle_ex(); csr_redirect = 0; csr_target = 0;
    halt = 0; if_ready = 1;
    m_mode = 0; m_pc = 0; m_flush = 0; m_mis = 0; m_cnt = 0;

    step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h8000_0000);
    chk("rst_cnt", taken_cnt, 32'd0);
    rst = 0;
    step();
    chk("boot_pc", if_pc, 32'h8000_0000);
    repeat (4) step();
    chk("seq_pc", if_pc, 32'h8000_0010);

    if_ready = 0;
    repeat (3) step();
    chk("hold_pc", if_pc, 32'h8000_0010);
    chk("hold_valid", 32'(if_valid), 32'd1);
    if_ready = 1;
    step();
    chk("accept_pc", if_pc, 32'h8000_0014);

    ex_valid = 1; ex_branch = 3'b100; ex_zero = 1;
    ex_pc = 32'h8000_0020; ex_imm = 32'hFFFF_FFF0;
    step();
    chk("beq_pc", if_pc, 32'h8000_0010);
    chk("beq_flush", 32'(flush), 32'd1);
    chk("beq_cnt", taken_cnt, 32'd1);

    ex_branch = 3'b101;
    step();
    chk("bne_pc", if_pc, 32'h8000_0014);
    chk("bne_flush", 32'(flush), 32'd0);

    ex_branch = 3'b010; ex_rs1 = 32'h8000_0101; ex_imm = 0;
    step();
    chk("jalr_pc", if_pc, 32'h8000_0100);

    ex_branch = 3'b001; ex_pc = 32'h8000_0100; ex_imm = 32'h2;
    step();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_pc", if_pc, 32'h8000_0104);
    chk("mis_cnt", taken_cnt, 32'd2);

    ex_pc = 32'h8000_0000; ex_imm = 32'h200;
    csr_redirect = 1; csr_target = 32'h8000_1000; if_ready = 0;
    step();
    chk("csr_pc", if_pc, 32'h8000_1000);
    chk("csr_cnt", taken_cnt, 32'd3);
    csr_redirect = 0; if_ready = 1;

    ex_branch = 3'b100; ex_zero = 1;
    ex_pc = 32'hFFFF_FFFC; ex_imm = 32'd8;
    step();
    chk("wrap_pc", if_pc, 32'h0000_0004);
    chk("cnt2_wrap", 32'(taken_cnt2), 32'd0);
    idle_ex();

    halt = 1;
    step();
    chk("halt_valid", 32'(if_valid), 32'd0);
    halt = 0; csr_redirect = 1; csr_target = 32'h1234_0000;
    repeat (2) step();
    chk("halt_pc", if_pc, 32'h0000_0008);
    csr_redirect = 0; rst = 1;
    step();
    chk("rst2_pc", if_pc, 32'h8000_0000);
    chk("rst2_cnt", taken_cnt, 32'd0);
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      halt         = ($urandom_range(0, 39) == 0);
      csr_redirect = ($urandom_range(0, 7) == 0);
      csr_target   = $urandom & ~32'd3;
      if_ready     = $urandom_range(0, 3) != 0;
      ex_valid     = $urandom_range(0, 1) == 1;
      ex_branch    = 3'($urandom);
      ex_zero      = 1'($urandom);
      ex_less      = 1'($urandom);
      ex_pc        = $urandom & ~32'd3;
      ex_rs1       = $urandom;
      ex_imm       = ($urandom_range(0, 3) == 0)
                   ? $urandom : (32'($urandom_range(0, 64)) << 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
